// File: rtl/mp3_pkg.sv
// mp3_pkg: SCI opcodes/registers and controller state encoding shared by the VS10xx driver.
package mp3_pkg;
  localparam logic [7:0] SCI_WRITE = 8'h02;
  localparam logic [7:0] SCI_MODE = 8'h00;
  localparam logic [7:0] SCI_VOL = 8'h0B;
  typedef enum logic [2:0] {RST_WAIT, CMD_WAIT, CMD_SHIFT, DATA_WAIT, FETCH, DATA_SHIFT} state_t;
  function automatic logic [31:0] sci_frame(input logic [7:0] a, input logic [15:0] v);
    return {SCI_WRITE, a, v};
  endfunction
endpackage

// File: rtl/mp3_spi_shifter.sv
// mp3_spi_shifter: SPI mode-0 MSB-first frame shifter with a half-period of CS setup and hold.
module mp3_spi_shifter #(
  parameter int CLK_DIV = 50,
  parameter int MAX_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [$clog2(MAX_W+1)-1:0]   len,
  input  logic [MAX_W-1:0]             data,
  output logic                         done,
  output logic                         sck,
  output logic                         si,
  output logic                         cs_n
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int HW = $clog2(2*MAX_W+1);
  logic [CW-1:0] cnt;
  logic [HW-1:0] rem;
  logic [MAX_W-1:0] sr;
  logic active;
  assign si = active & sr[MAX_W-1];
  assign cs_n = ~active;
  // 2*len SCK toggles plus one trailing low half-period before CS is released
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt <= '0;
      rem <= '0;
      sr <= '0;
      sck <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (load) begin
          active <= 1'b1;
          cnt <= '0;
          rem <= HW'(2 * len);
          sr <= data;
        end
      end else if (cnt != CW'(CLK_DIV - 1)) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        if (rem == '0) begin
          active <= 1'b0;
          done <= 1'b1;
        end else begin
          rem <= rem - 1'b1;
          sck <= ~sck;
          if (sck) sr <= sr << 1;
        end
      end
    end
  end
endmodule

// File: rtl/mp3_stream_ctrl.sv
// mp3_stream_ctrl: VS10xx driver - reset, SCI init, DREQ-paced looping SDI stream with volume and pause.
module mp3_stream_ctrl
  import mp3_pkg::*;
#(
  parameter int CLK_DIV = 50,
  parameter int RESET_DLY = 50_000_000,
  parameter int ID_W = 3,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter logic [15:0] MODE_INIT = 16'h0804,
  parameter logic [15:0] VOL_INIT = 16'h8080
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ID_W-1:0]        music_id,
  input  logic                   vol_wr,
  input  logic [15:0]            vol_val,
  output logic [ID_W+ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0]      rom_data,
  output logic                   track_end,
  output logic                   busy,
  output logic                   XRSET,
  input  logic                   DREQ,
  output logic                   XCS,
  output logic                   XDCS,
  output logic                   SI,
  output logic                   SCK
);
  localparam int SW = DATA_W > 32 ? DATA_W : 32;
  localparam int LW = $clog2(SW + 1);
  localparam int DW = $clog2(RESET_DLY + 1);
  state_t state, nxt;
  logic [DW-1:0] dly;
  logic [1:0] dreq_q, init;
  logic dreq_s, vol_pend, sdi, load, done, cs_n;
  logic [15:0] vol_reg;
  logic [ADDR_W-1:0] addr;
  logic [ID_W-1:0] cur_id;
  logic [LW-1:0] len;
  logic [SW-1:0] sdata;
  logic [31:0] cmd;
  assign dreq_s = dreq_q[1];
  assign rom_addr = {cur_id, addr};
  assign XCS = sdi | cs_n;
  assign XDCS = ~sdi | cs_n;
  assign busy = ~(XCS & XDCS);
  assign cmd = init == 2'd0 ? sci_frame(SCI_MODE, MODE_INIT) :
               init == 2'd1 ? sci_frame(SCI_VOL, VOL_INIT) : sci_frame(SCI_VOL, vol_reg);
  assign len = state == FETCH ? LW'(DATA_W) : LW'(32);
  assign sdata = state == FETCH ? SW'(rom_data) << (SW - DATA_W) : SW'(cmd) << (SW - 32);
  mp3_spi_shifter #(.CLK_DIV(CLK_DIV), .MAX_W(SW)) u_spi (
    .clk(clk), .rst(rst), .load(load), .len(len), .data(sdata),
    .done(done), .sck(SCK), .si(SI), .cs_n(cs_n)
  );
  always_ff @(posedge clk) state <= rst ? RST_WAIT : nxt;
  // A track change is absorbed in DATA_WAIT so the ROM sees the new address a cycle before FETCH
  always_comb begin
    nxt = state;
    load = 1'b0;
    case (state)
      RST_WAIT: nxt = dly == DW'(RESET_DLY - 1) ? CMD_WAIT : RST_WAIT;
      CMD_WAIT: begin
        load = dreq_s;
        nxt = dreq_s ? CMD_SHIFT : CMD_WAIT;
      end
      CMD_SHIFT: nxt = !done ? CMD_SHIFT : init == 2'd2 ? DATA_WAIT : CMD_WAIT;
      DATA_WAIT: begin
        load = dreq_s & vol_pend;
        nxt = (dreq_s & vol_pend) ? CMD_SHIFT :
              (dreq_s & start & (music_id == cur_id)) ? FETCH : DATA_WAIT;
      end
      FETCH: begin
        load = 1'b1;
        nxt = DATA_SHIFT;
      end
      DATA_SHIFT: nxt = done ? DATA_WAIT : DATA_SHIFT;
      default: nxt = RST_WAIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dly <= '0;
      XRSET <= 1'b0;
      dreq_q <= '0;
      init <= '0;
      vol_pend <= 1'b0;
      vol_reg <= '0;
      addr <= '0;
      cur_id <= '0;
      sdi <= 1'b0;
      track_end <= 1'b0;
    end else begin
      dreq_q <= {dreq_q[0], DREQ};
      track_end <= state == DATA_SHIFT && done && (&addr);
      if (state == RST_WAIT) dly <= dly + 1'b1;
      if (state == RST_WAIT && nxt == CMD_WAIT) XRSET <= 1'b1;
      if (load) sdi <= state == FETCH;
      if (load && state == CMD_WAIT) init <= init + 1'b1;
      if (vol_wr) begin
        vol_reg <= vol_val;
        vol_pend <= 1'b1;
      end else if (load && state == DATA_WAIT) begin
        vol_pend <= 1'b0;
      end
      if (state == DATA_SHIFT && done) addr <= addr + 1'b1;
      if (state == DATA_WAIT && music_id != cur_id) begin
        cur_id <= music_id;
        addr <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mp3_stream_ctrl.sv
// tb_mp3_stream_ctrl: decoder BFM plus frame scoreboard for the VS10xx stream controller.
module tb_mp3_stream_ctrl;
  logic clk = 0, rst = 1, start = 0, vol_wr = 0, DREQ = 1;
  logic [2:0] music_id = 0;
  logic [15:0] vol_val = 0, rom_data;
  logic [5:0] rom_addr;
  logic track_end, busy, XRSET, XCS, XDCS, SI, SCK;
  int total = 0, bad = 0, popped = 0, te_cnt = 0, nb = 0;
  logic [32:0] exp_q[$];
  logic [31:0] sh = 0;
  logic pcs = 1, pdcs = 1;
  always #5 clk = ~clk;
  mp3_stream_ctrl #(.CLK_DIV(2), .RESET_DLY(10), .ID_W(3), .ADDR_W(3), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .music_id(music_id), .vol_wr(vol_wr), .vol_val(vol_val),
    .rom_addr(rom_addr), .rom_data(rom_data), .track_end(track_end), .busy(busy), .XRSET(XRSET),
    .DREQ(DREQ), .XCS(XCS), .XDCS(XDCS), .SI(SI), .SCK(SCK)
  );
  always @(posedge clk) rom_data <= 16'hA500 + 16'(rom_addr);
  always @(posedge clk) if (track_end === 1'b1) te_cnt <= te_cnt + 1;
  task automatic frame_end(input logic kind);
    logic [32:0] e, g;
    if (rst === 1'b1) return;
    total++;
    g = {kind, kind ? {16'h0, sh[15:0]} : sh};
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL frame_unexpected got kind=%0d bits=%0d val=%h", kind, nb, g[31:0]);
    end else begin
      e = exp_q.pop_front();
      popped++;
      if (g !== e || nb != (kind ? 16 : 32)) begin
        bad++;
        $display("FAIL frame got kind=%0d bits=%0d val=%h, want kind=%0d bits=%0d val=%h",
                 kind, nb, g[31:0], e[32], e[32] ? 16 : 32, e[31:0]);
      end
    end
  endtask
  always @(posedge SCK or XCS or XDCS) begin
    if (XCS !== pcs || XDCS !== pdcs) begin
      if (XCS === 1'b0 && XDCS === 1'b0) begin
        total++;
        bad++;
        $display("FAIL cs_overlap got XCS=0 XDCS=0, want at most one low");
      end
      if (pcs === 1'b0 && XCS === 1'b1) frame_end(1'b0);
      if (pdcs === 1'b0 && XDCS === 1'b1) frame_end(1'b1);
      if ((pcs === 1'b1 && XCS === 1'b0) || (pdcs === 1'b1 && XDCS === 1'b0)) begin
        sh = 0;
        nb = 0;
      end
      pcs = XCS;
      pdcs = XDCS;
    end else if (SCK === 1'b1) begin
      if (XCS === 1'b1 && XDCS === 1'b1 && rst === 1'b0) begin
        total++;
        bad++;
        $display("FAIL sck_no_cs got SCK rise with both CS high, want none");
      end
      sh = {sh[30:0], SI};
      nb++;
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask
  task automatic wait_pop(input int n);
    for (int t = 0; t < 20000 && popped < n; t++) @(negedge clk);
    check("frames_popped", popped, n);
  endtask
  task automatic wait_xdcs_low();
    for (int t = 0; t < 2000 && XDCS !== 1'b0; t++) @(negedge clk);
    check("xdcs_start", {31'd0, XDCS}, 0);
  endtask
  task automatic count_xrset();
    int c = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (XRSET !== 1'b0) break;
      c++;
    end
    check("xrset_low_cycles", c, 10);
  endtask
  task automatic push_sdi(input int n);
    exp_q.push_back({1'b1, 16'h0, 16'hA500 + 16'(n)});
  endtask
  task automatic push_init();
    exp_q.push_back({1'b0, 32'h0200_0804});
    exp_q.push_back({1'b0, 32'h020B_8080});
  endtask
  task automatic idle_check(input string name, input int cycles);
    int lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) lows++;
    end
    check(name, lows, 0);
  endtask
  initial begin
    push_init();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {XRSET, XCS, XDCS, SCK, SI, track_end, busy, rom_addr}, 13'b0110000000000);
    @(posedge clk);
    #1 rst = 0;
    count_xrset();
    wait_pop(2);
    // stream: full track, wrap, then DREQ stall after the third word of the second pass
    for (int n = 0; n < 8; n++) push_sdi(n);
    for (int n = 0; n < 3; n++) push_sdi(n);
    start = 1;
    wait_pop(12);
    check("track_end_count_wrap", te_cnt, 1);
    wait_xdcs_low();
    DREQ = 0;
    wait_pop(13);
    idle_check("dreq_idle", 100);
    check("dreq_hold_addr", rom_addr, 3);
    // double volume write mid-word: only the last value goes out
    push_sdi(3);
    DREQ = 1;
    wait_xdcs_low();
    repeat (10) @(negedge clk);
    vol_val = 16'h2020;
    vol_wr = 1;
    @(negedge clk) vol_wr = 0;
    repeat (10) @(negedge clk);
    vol_val = 16'h1010;
    vol_wr = 1;
    @(negedge clk) vol_wr = 0;
    exp_q.push_back({1'b0, 32'h020B_1010});
    push_sdi(4);
    push_sdi(5);
    wait_pop(16);
    wait_xdcs_low();
    start = 0;
    wait_pop(17);
    idle_check("pause_idle", 200);
    check("pause_addr", rom_addr, 6);
    // resume then switch track mid-word
    push_sdi(6);
    push_sdi(8);
    push_sdi(9);
    start = 1;
    wait_xdcs_low();
    music_id = 1;
    wait_pop(19);
    wait_xdcs_low();
    start = 0;
    wait_pop(20);
    idle_check("track_switch_idle", 20);
    check("track_switch_addr", rom_addr, {3'd1, 3'd2});
    check("track_end_no_pulse_on_switch", te_cnt, 1);
    // reset in the middle of a data word
    start = 1;
    wait_xdcs_low();
    repeat (20) @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1 check("rst_abort_pins", {XRSET, XCS, XDCS, SCK}, 4'b0110);
    check("rst_abort_state", {rom_addr, busy, track_end}, 0);
    start = 0;
    music_id = 0;
    push_init();
    rst = 0;
    count_xrset();
    wait_pop(22);
    idle_check("post_reinit_idle", 50);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
